compare_seq_ctrl: RTL
=====================

Name: compare_seq_ctrl

Overview:
Multi-cycle sequencer for the pipeline's signed/unsigned less-than compare path (SLT/SLTU/BLT/BLTU class).
- Registers one operand pair per request.
- Resolves the sign bit first, then scans CHUNK-bit slices from MSB to LSB, stopping at the first differing slice.
- Returns a zero-extended XLEN-bit result over a valid/ready handshake to the execute stage.
- Replaces a single-cycle 64-bit ripple compare on timing-critical paths.

Parameters:
XLEN, 64, operand and result width
CHUNK, 8, bits examined per SCAN cycle; XLEN % CHUNK == 0 required

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  controller can accept a request
rs1  in  XLEN  operand A
rs2  in  XLEN  operand B
is_unsigned  in  1  1 = unsigned compare, 0 = signed
flush  in  1  synchronous abort of the in-flight request
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
result  out  XLEN  {(XLEN-1)'b0, lt}; lt=1 iff rs1 < rs2
busy  out  1  state != IDLE

Behaviour:
- Reset: on a clk edge with rst_n=0, state=IDLE, out_valid=0, result=0, busy=0, in_ready=0 in that cycle; operand registers and chunk index are cleared. Reset mid-operation discards the request with no output.
- in_ready = (state==IDLE) && rst_n. Accept happens when in_valid && in_ready; rs1, rs2 and is_unsigned are latched and the FSM goes to SIGN.
- Chunk index idx is a counter of width clog2(XLEN/CHUNK).
- State IDLE: wait for accept.
- State SIGN (accept cycle T, SIGN evaluated in T+1):
  - Signed and rs1[XLEN-1] != rs2[XLEN-1]: lt = rs1[XLEN-1]; go to DONE.
  - Otherwise: idx = XLEN/CHUNK-1; go to SCAN.
- State SCAN (the top chunk is evaluated in T+2; slice = bits [idx*CHUNK+CHUNK-1 : idx*CHUNK]):
  - Slices are compared unsigned. In signed mode with equal signs, an unsigned compare is correct.
  - Slices differ: lt = (slice1 < slice2); go to DONE.
  - Slices equal and idx==0: lt=0; go to DONE.
  - Otherwise: idx = idx-1; stay in SCAN.
- State DONE: out_valid=1 and result is driven. result stays stable while out_valid && !out_ready. On out_ready, go to IDLE with out_valid=0 in the next cycle. No accept occurs in the same cycle as the DONE handshake; minimum request spacing is one IDLE cycle.
- Latency from accept cycle T to first out_valid cycle:
  - Signs differ (signed): T+2.
  - Decision in scan step k (k=0 is the top chunk): T+3+k.
  - Worst case, equal operands with XLEN=64 and CHUNK=8: T+10.
- Flush: has priority over all transitions; state goes to IDLE next cycle, out_valid=0, result is dropped. Flush while in IDLE with in_valid=1 blocks the accept.
- Simultaneous flush with a DONE handshake: the flush wins; the consumer must treat out_valid in a flush cycle as killed.
- result bits [XLEN-1:1] are always 0; result holds its last value in IDLE (reset clears it to 0).

Optional Feature:
COMPARE_EARLY_EQ_EN
- Defined: SIGN also checks full equality. If rs1==rs2, lt=0 and the FSM goes to DONE, so out_valid appears at T+2.
- Undefined: equal operands walk every chunk, giving worst-case latency. The result value is identical in both builds.

Test Plan:
1. Reset, then signed rs1=64'hFFFF_FFFF_FFFF_FFFF (-1), rs2=1, accepted at T -> out_valid at T+2, result=1. Same operands with is_unsigned=1 -> top chunk 8'hFF vs 8'h00 decides, out_valid at T+3, result=0.
2. Signed rs1=5, rs2=7 (difference only in chunk 0) -> out_valid at T+10, result=1; swap operands -> result=0 at T+10.
3. rs1=rs2=64'h1234_5678_9ABC_DEF0 -> result=0. Without the macro, out_valid at T+10; with COMPARE_EARLY_EQ_EN, out_valid at T+2.
4. Hold out_ready=0 for 5 cycles after out_valid -> out_valid and result=1 stay stable and in_ready=0; release -> out_valid=0 and in_ready=1 next cycle.
5. Pulse flush at T+4 mid-scan -> IDLE at T+5 with no out_valid. Drive rst_n=0 at T+3 in another run -> all outputs 0 next edge and the request is lost.
6. Back-to-back requests with in_valid held high and out_ready=1 -> the second accept happens exactly one cycle after the first DONE handshake; both results correct (e.g. -8 < -3 signed -> 1; 64'h8000_0000_0000_0000 < 1 unsigned -> 0).

Source files
------------

// File: rtl/compare_seq_ctrl_if.sv
// Request/response bundle for the multi-cycle less-than compare sequencer.
// The master side is the execute stage; the slave side is the sequencer.
interface compare_seq_ctrl_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            is_unsigned;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid,
        output rs1,
        output rs2,
        output is_unsigned,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  rs1,
        input  rs2,
        input  is_unsigned,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output busy
    );
endinterface

// File: rtl/compare_seq_ctrl.sv
// Multi-cycle signed/unsigned less-than sequencer: sign step, then MSB-first chunk scan.
// Optional macro COMPARE_EARLY_EQ_EN adds a full-equality shortcut in the sign step.
module compare_seq_ctrl #(
    parameter int XLEN  = 64,
    parameter int CHUNK = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    compare_seq_ctrl_if.slave   bus
);
    // XLEN must be a whole multiple of CHUNK.
    localparam int NCH  = XLEN / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SIGN = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   rs1_q, rs1_d;
    logic [XLEN-1:0]   rs2_q, rs2_d;
    logic              uns_q, uns_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              lt_q, lt_d;

    logic [CHUNK-1:0]  ch1 [NCH];
    logic [CHUNK-1:0]  ch2 [NCH];
    logic [CHUNK-1:0]  slice1;
    logic [CHUNK-1:0]  slice2;
    logic              accept;
    logic              signs_differ;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chunk
            assign ch1[gi] = rs1_q[gi*CHUNK +: CHUNK];
            assign ch2[gi] = rs2_q[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign slice1       = ch1[idx_q];
    assign slice2       = ch2[idx_q];
    assign signs_differ = rs1_q[XLEN-1] ^ rs2_q[XLEN-1];

    assign bus.in_ready  = (state_q == IDLE) && rst_n;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.result    = {{(XLEN-1){1'b0}}, lt_q};

    // A flush in IDLE must also suppress the accept, so it is folded in here.
    assign accept = bus.in_valid && bus.in_ready && !bus.flush;

    always_comb begin
        state_d = state_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        uns_d   = uns_q;
        idx_d   = idx_q;
        lt_d    = lt_q;

        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        rs1_d   = bus.rs1;
                        rs2_d   = bus.rs2;
                        uns_d   = bus.is_unsigned;
                        state_d = SIGN;
                    end
                end
                SIGN: begin
                    if (!uns_q && signs_differ) begin
                        // Negative operand is the smaller one.
                        lt_d    = rs1_q[XLEN-1];
                        state_d = DONE;
`ifdef COMPARE_EARLY_EQ_EN
                    end else if (rs1_q == rs2_q) begin
                        lt_d    = 1'b0;
                        state_d = DONE;
`endif
                    end else begin
                        idx_d   = IDXW'(NCH - 1);
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    // With equal signs an unsigned slice compare is also correct for signed.
                    if (slice1 != slice2) begin
                        lt_d    = (slice1 < slice2);
                        state_d = DONE;
                    end else if (idx_q == '0) begin
                        lt_d    = 1'b0;
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q - IDXW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rs1_q   <= '0;
            rs2_q   <= '0;
            uns_q   <= 1'b0;
            idx_q   <= '0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            uns_q   <= uns_d;
            idx_q   <= idx_d;
            lt_q    <= lt_d;
        end
    end
endmodule
